// File: rtl/control_unit_pkg.sv
// Shared definitions for the microcoded control unit: opcode map, control-word
// bit layout and the default T-state count.
package control_unit_pkg;

  localparam int STEPS_DEFAULT = 5;
  localparam int CW_WIDTH      = 16;

  typedef logic [2:0] step_t;
  typedef logic [CW_WIDTH-1:0] ctrl_word_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // write_B has no microcode use, so it has no bit in the 16-bit word.
  localparam int CW_HLT  = 15;
  localparam int CW_MI   = 14;
  localparam int CW_RI   = 13;
  localparam int CW_RO   = 12;
  localparam int CW_IO   = 11;
  localparam int CW_II   = 10;
  localparam int CW_LA   = 9;
  localparam int CW_WA   = 8;
  localparam int CW_SU   = 7;
  localparam int CW_WALU = 6;
  localparam int CW_LB   = 5;
  localparam int CW_OI   = 4;
  localparam int CW_CE   = 3;
  localparam int CW_CO   = 2;
  localparam int CW_J    = 1;
  localparam int CW_FI   = 0;

  function automatic ctrl_word_t cw_bit(input int idx);
    cw_bit = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-line bundle between the control unit and the ALU, RAM, PC and
// output blocks; the shared data bus stays a plain inout on the top.
interface control_unit_if;
  import control_unit_pkg::*;

  logic        carry_in;
  logic        zero_in;
  logic        load_A;
  logic        load_B;
  logic        write_A;
  logic        write_B;
  logic        write_ALU;
  logic        subtract;
  logic        MI;
  logic        RO;
  logic        RI;
  logic        CO;
  logic        CE;
  logic        J;
  logic        II;
  logic        IO;
  logic        OI;
  logic        FI;
  logic        HLT;
  step_t       step;
  logic [3:0]  opcode;

  modport master (
    input  carry_in, zero_in,
    output load_A, load_B, write_A, write_B, write_ALU, subtract,
           MI, RO, RI, CO, CE, J, II, IO, OI, FI, HLT, step, opcode
  );

  modport slave (
    output carry_in, zero_in,
    input  load_A, load_B, write_A, write_B, write_ALU, subtract,
           MI, RO, RI, CO, CE, J, II, IO, OI, FI, HLT, step, opcode
  );

endinterface

// File: rtl/control_unit_microcode_rom.sv
// Combinational microcode: {opcode, step, C, Z} -> 16-bit control word.
module microcode_rom
  import control_unit_pkg::*;
(
  input  logic [3:0] opcode,
  input  step_t      step,
  input  logic       c,
  input  logic       z,
  output ctrl_word_t cw
);

  opcode_e op_s;
  assign op_s = opcode_e'(opcode);

  // Fetch in T0/T1 is shared; execute words depend on opcode and flags.
  always_comb begin
    cw = 16'h0000;
    case (step)
      3'd0: cw = cw_bit(CW_CO) | cw_bit(CW_MI);
      3'd1: cw = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
      3'd2: begin
        case (op_s)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: cw = cw_bit(CW_IO) | cw_bit(CW_MI);
          OP_LDI: cw = cw_bit(CW_IO) | cw_bit(CW_LA);
          OP_JMP: cw = cw_bit(CW_IO) | cw_bit(CW_J);
          OP_JC: begin
            if (c) cw = cw_bit(CW_IO) | cw_bit(CW_J);
            else   cw = 16'h0000;
          end
          OP_JZ: begin
            if (z) cw = cw_bit(CW_IO) | cw_bit(CW_J);
            else   cw = 16'h0000;
          end
          OP_OUT: cw = cw_bit(CW_WA) | cw_bit(CW_OI);
          OP_HLT: cw = cw_bit(CW_HLT);
          default: cw = 16'h0000;
        endcase
      end
      3'd3: begin
        case (op_s)
          OP_LDA:         cw = cw_bit(CW_RO) | cw_bit(CW_LA);
          OP_ADD, OP_SUB: cw = cw_bit(CW_RO) | cw_bit(CW_LB);
          OP_STA:         cw = cw_bit(CW_WA) | cw_bit(CW_RI);
          default:        cw = 16'h0000;
        endcase
      end
      3'd4: begin
        case (op_s)
          OP_ADD:  cw = cw_bit(CW_WALU) | cw_bit(CW_LA) | cw_bit(CW_FI);
          OP_SUB:  cw = cw_bit(CW_WALU) | cw_bit(CW_LA) | cw_bit(CW_FI) | cw_bit(CW_SU);
          default: cw = 16'h0000;
        endcase
      end
      default: cw = 16'h0000;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microcoded control sequencer: instruction register, T-state counter and
// carry/zero flags, driving the computer's control lines from microcode.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int STEPS = STEPS_DEFAULT
) (
  input  logic           clk,
  input  logic           clr,
  inout  wire  [7:0]     bus,
  control_unit_if.master cu
);

  localparam step_t STEP_LAST = 3'(STEPS - 1);

  logic [7:0] ir_r;
  step_t      step_r;
  logic       c_r;
  logic       z_r;
  ctrl_word_t rom_cw_s;
  ctrl_word_t cw_s;

  microcode_rom u_rom (
    .opcode (ir_r[7:4]),
    .step   (step_r),
    .c      (c_r),
    .z      (z_r),
    .cw     (rom_cw_s)
  );

  // clr masks the decode so no line (including the T0 fetch word) is live in reset.
  always_comb begin
    if (clr) cw_s = 16'h0000;
    else     cw_s = rom_cw_s;
  end

  // IR, step counter and flags; a decoded HLT freezes IR and step until clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ir_r   <= 8'h00;
      step_r <= 3'd0;
      c_r    <= 1'b0;
      z_r    <= 1'b0;
    end else begin
      if (!rom_cw_s[CW_HLT]) begin
        if (rom_cw_s[CW_II]) ir_r <= bus;
        else                 ir_r <= ir_r;
        if (step_r == STEP_LAST) step_r <= 3'd0;
        else                     step_r <= step_r + 3'd1;
      end else begin
        ir_r   <= ir_r;
        step_r <= step_r;
      end
      if (rom_cw_s[CW_FI]) begin
        c_r <= cu.carry_in;
        z_r <= cu.zero_in;
      end else begin
        c_r <= c_r;
        z_r <= z_r;
      end
    end
  end

  assign bus = cw_s[CW_IO] ? {4'b0000, ir_r[3:0]} : 8'hzz;

  assign cu.load_A    = cw_s[CW_LA];
  assign cu.load_B    = cw_s[CW_LB];
  assign cu.write_A   = cw_s[CW_WA];
  assign cu.write_B   = 1'b0;
  assign cu.write_ALU = cw_s[CW_WALU];
  assign cu.subtract  = cw_s[CW_SU];
  assign cu.MI        = cw_s[CW_MI];
  assign cu.RO        = cw_s[CW_RO];
  assign cu.RI        = cw_s[CW_RI];
  assign cu.CO        = cw_s[CW_CO];
  assign cu.CE        = cw_s[CW_CE];
  assign cu.J         = cw_s[CW_J];
  assign cu.II        = cw_s[CW_II];
  assign cu.IO        = cw_s[CW_IO];
  assign cu.OI        = cw_s[CW_OI];
  assign cu.FI        = cw_s[CW_FI];
  assign cu.HLT       = cw_s[CW_HLT];
  assign cu.step      = step_r;
  assign cu.opcode    = ir_r[7:4];

endmodule
